// File: rtl/gba_bw_frame_streamer.sv
// rtl/gba_bw_frame_streamer.sv - streams 1bpp image banks out as RGB565 pixels
// One byte is fetched per FETCH/WAIT pair and then expanded MSB-first over eight EMIT handshakes.

module gba_bw_frame_streamer #(
    parameter int          NUM_BANKS   = 4,
    parameter int          ADDR_W      = 9,
    parameter int          FRAME_BYTES = 1600,
    parameter logic [15:0] ONE_COLOR   = 16'hFFFF,
    parameter logic [15:0] ZERO_COLOR  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_BANKS-1:0]   rd_en_o,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [8*NUM_BANKS-1:0] rd_data_i,
    input  logic [NUM_BANKS-1:0]   rd_valid_i,
    output logic [15:0]            pix_data_o,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W  = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       b_q;
    logic [CNT_W-1:0]       b_d;
    logic [BANK_W-1:0]      bank_cur;
    logic [BANK_W-1:0]      bank_nxt;
    logic [7:0]             rd_byte;
    logic [7:0]             shreg_q;
    logic [2:0]             idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NUM_BANKS-1:0]   rd_en_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [15:0]            pix_data_q;
    logic                   pix_valid_q;

    assign b_d      = b_q + CNT_W'(1);
    assign bank_cur = b_q[CNT_W-1:ADDR_W];
    assign bank_nxt = b_d[CNT_W-1:ADDR_W];
    assign rd_byte  = rd_data_i[8*bank_cur +: 8];

    function automatic logic [15:0] color(input logic bit_v);
        return bit_v ? ONE_COLOR : ZERO_COLOR;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            shreg_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= '0;
            rd_addr_q   <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        b_q       <= '0;
                        rd_en_q   <= NUM_BANKS'(1);
                        rd_addr_q <= '0;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Only the bank being read may release the wait.
                    if (rd_valid_i[bank_cur]) begin
                        shreg_q     <= rd_byte;
                        idx_q       <= 3'd7;
                        pix_data_q  <= color(rd_byte[7]);
                        pix_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (pix_ready_i) begin
                        shreg_q <= shreg_q << 1;
                        if (idx_q == 3'd0) begin
                            pix_valid_q <= 1'b0;
                            if (b_q == LAST_BYTE) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                b_q       <= b_d;
                                rd_en_q   <= NUM_BANKS'(1) << bank_nxt;
                                rd_addr_q <= b_d[ADDR_W-1:0];
                                state_q   <= S_FETCH;
                            end
                        end else begin
                            idx_q      <= idx_q - 3'd1;
                            pix_data_q <= color(shreg_q[6]);
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign pix_data_o  = pix_data_q;
    assign pix_valid_o = pix_valid_q;

endmodule

// File: tb/tb_gba_bw_frame_streamer.sv
// tb/tb_gba_bw_frame_streamer.sv - scoreboard and vector-table bench for gba_bw_frame_streamer

module tb_gba_bw_frame_streamer;

    localparam int NPIX = 12800;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pix_ready;
    logic        busy_o, done_o, pix_valid_o;
    logic [3:0]  rd_en_o;
    logic [8:0]  rd_addr_o;
    logic [15:0] pix_data_o;
    logic [31:0] rd_data;
    logic [3:0]  valid_r = '0;
    logic [7:0]  data_r [4];
    logic [3:0]  pend = '0;
    int          dly [4];

    logic [7:0]  mem [4][512];
    logic [15:0] exp_q [$];
    logic [15:0] cap [NPIX];
    int          extra_lat = 0;
    bit          spur2 = 0;
    bit          stall_en = 0;
    int          stall_left = 0;
    int          acc_cnt = 0, fetch_n = 0, done_cnt = 0;
    int          vec_n = 0, miscompares = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data;

    typedef struct {
        int           idx;
        logic [7:0]   data;
        int           stall_px;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [8];
    bit   stalled [8];

    gba_bw_frame_streamer dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data), .rd_valid_i(valid_r),
        .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready)
    );

    assign rd_data = {data_r[3], data_r[2], data_r[1], data_r[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: one-cycle latency, optional extra latency and spurious bank2 valid.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            valid_r[k] <= 1'b0;
            if (rd_en_o[k]) begin
                data_r[k] <= mem[k][rd_addr_o];
                if (extra_lat == 0) valid_r[k] <= 1'b1;
                else begin
                    pend[k] <= 1'b1;
                    dly[k]  <= extra_lat;
                end
            end else if (pend[k]) begin
                if (dly[k] <= 1) begin
                    valid_r[k] <= 1'b1;
                    pend[k]    <= 1'b0;
                end else dly[k] <= dly[k] - 1;
            end
        end
        if (spur2) valid_r[2] <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_n++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_frame();
        logic [7:0] byte_v;
        for (int i = 0; i < 1600; i++) begin
            byte_v = mem[i >> 9][i & 511];
            for (int j = 7; j >= 0; j--) exp_q.push_back(byte_v[j] ? 16'hFFFF : 16'h0000);
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("done_within_budget", 32'(done_cnt > 0), 32'd1);
    endtask

    // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 0;
            else begin
                if (prev_stall)
                    chk("pix_hold", {15'd0, pix_valid_o, pix_data_o}, {15'd0, 1'b1, prev_data});
                prev_stall = pix_valid_o && !pix_ready;
                prev_data  = pix_data_o;
                if (pix_valid_o && pix_ready) begin
                    if (exp_q.size() == 0) chk("pixel_unexpected", 32'(acc_cnt), 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("pixel", {16'd0, pix_data_o}, {16'd0, e});
                    end
                    if (acc_cnt < NPIX) cap[acc_cnt] = pix_data_o;
                    acc_cnt++;
                end
                if (rd_en_o != 4'd0) begin
                    chk("fetch_en_addr", 32'({rd_en_o, rd_addr_o}),
                        32'({4'(1 << (fetch_n >> 9)), 9'(fetch_n & 511)}));
                    fetch_n++;
                end
                if (done_o) done_cnt++;
            end
        end
    end

    // Ready driver: holds ready high except for 5-cycle stalls keyed to accepted-pixel count.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else begin
                pix_ready = 1'b1;
                if (stall_en)
                    for (int v = 0; v < 8; v++)
                        if (vecs[v].stall_px >= 0 && !stalled[v] &&
                            acc_cnt == vecs[v].idx * 8 + vecs[v].stall_px) begin
                            stalled[v] = 1'b1;
                            pix_ready  = 1'b0;
                            stall_left = 4;
                        end
            end
        end
    end

    initial begin
        int t;
        logic [127:0] ev;
        vecs[0] = '{484,  8'hE0, -1, 128'hFFFF_FFFF_FFFF_0000_0000_0000_0000_0000};
        vecs[1] = '{100,  8'h01,  3, 128'h0000_0000_0000_0000_0000_0000_0000_FFFF};
        vecs[2] = '{511,  8'hA5, -1, 128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF};
        vecs[3] = '{512,  8'h3C,  7, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000};
        vecs[4] = '{1599, 8'h80, -1, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000};
        vecs[5] = '{0,    8'hFF, -1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{1024, 8'h5A, -1, 128'h0000_FFFF_0000_FFFF_FFFF_0000_FFFF_0000};
        vecs[7] = '{1100, 8'h00, -1, 128'h0000_0000_0000_0000_0000_0000_0000_0000};
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 512; a++) mem[k][a] = 8'($urandom);
        for (int v = 0; v < 8; v++) begin
            mem[vecs[v].idx >> 9][vecs[v].idx & 511] = vecs[v].data;
            stalled[v] = 1'b0;
        end

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy_o, done_o, rd_en_o, rd_addr_o, pix_valid_o, pix_data_o}, 32'd0);
        rst = 1'b0;

        // Abandon a frame mid-EMIT with an asynchronous reset.
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        t = 0;
        while (!(acc_cnt >= 30 && pix_valid_o) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("emit_reached", 32'(acc_cnt >= 30 && pix_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {busy_o, done_o, rd_en_o, rd_addr_o, pix_valid_o, pix_data_o}, 32'd0);
        exp_q.delete();
        acc_cnt = 0;
        fetch_n = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("no_done_after_abort", 32'(done_cnt), 32'd0);

        // Full frame with slow first byte, spurious bank2 valid and table-driven stalls.
        stall_en  = 1'b1;
        extra_lat = 3;
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("first_fetch_bank0", 32'(rd_en_o), 32'd1);
        @(posedge clk); #1;
        extra_lat = 0;
        spur2 = 1'b1;
        @(posedge clk); #1 spur2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("spurious_valid_ignored", 32'(pix_valid_o), 32'd0);
        wait_done(20000);
        @(posedge clk); #1;
        chk("f2_handshakes", 32'(acc_cnt), 32'(NPIX));
        chk("f2_fetches", 32'(fetch_n), 32'd1600);
        chk("f2_done_pulses", 32'(done_cnt), 32'd1);
        chk("f2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("f2_busy_low", 32'(busy_o), 32'd0);
        chk("f2_stalls_applied", 32'(stalled[1] && stalled[3]), 32'd1);
        for (int v = 0; v < 8; v++) begin
            ev = vecs[v].exp;
            for (int k = 0; k < 8; k++)
                chk($sformatf("table_v%0d_px%0d", v, k), {16'd0, cap[vecs[v].idx * 8 + k]},
                    {16'd0, ev[127 - 16 * k -: 16]});
        end

        // Ready held high; start held through busy and the done cycle must not re-trigger.
        stall_en = 1'b0;
        acc_cnt  = 0;
        fetch_n  = 0;
        done_cnt = 0;
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        t = 0;
        while (start && t < 20000) begin
            @(posedge clk); #1;
            if (done_cnt > 0) start = 1'b0;
            t++;
        end
        chk("f3_done_seen", 32'(done_cnt > 0), 32'd1);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("f3_handshakes", 32'(acc_cnt), 32'(NPIX));
        chk("f3_fetches", 32'(fetch_n), 32'd1600);
        chk("f3_done_pulses", 32'(done_cnt), 32'd1);
        chk("f3_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("f3_idle_after", 32'({busy_o, pix_valid_o, rd_en_o}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscompares);
        $finish;
    end

endmodule
